regfile_arbiter: RTL and testbench
==================================

Name: regfile_arbiter

Overview:
- Single owner of the 16-entry card regfile port set; replaces ad-hoc muxing of regfile write and read sources.
- Arbitrates four requesters, one operation per cycle:
  - colour writer (compute_colors): full-word writes.
  - state writer (state_machine): card-state-only writes.
  - single-card reader (card_press_checker).
  - 16-entry sweep engine, triggered by state_machine, streaming all cards to draw_cards.
- Sits between those requesters and regfile, on the 65 MHz pixel clock.

Parameters:
- DEPTH, 16, number of regfile entries; sweep visits 0..DEPTH-1.
- ADDR_W, 4, regfile address width.
- DATA_W, 14, word width: {colour[11:0], state[1:0]}.

Ports:
- clk  in  1  65 MHz clock
- rst  in  1  asynchronous reset, active-low
- wr0_req  in  1  colour-writer request, held until ack
- wr0_addr  in  ADDR_W  colour-writer address
- wr0_data  in  DATA_W  full word to write
- wr0_ack  out  1  comb., high in the cycle wr0 is granted
- wr1_req  in  1  state-writer request, held until ack
- wr1_addr  in  ADDR_W  state-writer address
- wr1_state  in  2  new card state
- wr1_ack  out  1  comb. grant for wr1
- rd_req  in  1  single-read request, held until ack
- rd_addr  in  ADDR_W  single-read address
- rd_ack  out  1  comb. grant for rd
- rd_valid  out  1  1-cycle pulse, rd_data valid
- rd_data  out  DATA_W  single-read result
- sweep_start  in  1  1-cycle pulse, start full sweep
- sweep_valid  out  1  sweep_data/sweep_index valid this cycle
- sweep_index  out  ADDR_W  entry index of sweep_data
- sweep_data  out  DATA_W  swept word
- sweep_done  out  1  1-cycle pulse with the last sweep_valid
- busy  out  1  sweep in progress or read data in flight
- regfile_w_enable  out  2  bit1 = write colour field, bit0 = write state field
- regfile_w_address  out  ADDR_W  registered write address
- regfile_w_data  out  DATA_W  registered write data
- regfile_r_address  out  ADDR_W  registered read address
- regfile_r_data  in  DATA_W  regfile data, valid 1 cycle after regfile_r_address

Behaviour:
- Reset (rst low, async): all registered outputs 0, FSM IDLE, sweep counter 0, no pending sweep, no in-flight read tags.
- Grant decision is combinational on the current cycle's requests. Priority: wr1 > wr0 > rd > sweep step.
- Only one grant per cycle; the ack is high only in the grant cycle. Requester drops req at the next edge.
- A write grant and a read grant are mutually exclusive: the regfile has a single operation slot per cycle.
- Write granted in cycle N → in cycle N+1:
  - wr0: regfile_w_enable=2'b11, regfile_w_data=wr0_data.
  - wr1: regfile_w_enable=2'b01, regfile_w_data={12'h000, wr1_state}.
  - regfile_w_address = the granted address.
  - regfile_w_enable=2'b00 in every non-write-grant cycle.
- Read (rd or sweep step) granted in cycle N:
  - regfile_r_address loaded for cycle N+1.
  - Data returned in cycle N+2 with a 1-cycle tag pipeline selecting rd_valid or sweep_valid.
  - rd_data/sweep_data are driven from regfile_r_data in that cycle.
  - Between valids, rd_data/sweep_data hold their last value.
- FSM:
  - IDLE: sweep_start → SWEEP, counter=0. A pending rd is unaffected.
  - SWEEP: each cycle without a higher-priority grant issues a read of counter, then counter++.
  - Preempted cycles stall the counter; no index is skipped or repeated.
  - After issuing index DEPTH-1 → DRAIN.
  - DRAIN: wait for the last sweep data, which arrives 2 cycles after issue. sweep_done pulses with the sweep_valid for index DEPTH-1, then → IDLE.
- sweep_start while not IDLE: ignored, no restart.
- sweep_start and requests in the same cycle: the sweep is accepted and its first step competes from the next cycle.
- busy = (state != IDLE) OR any read tag in flight.
- Reset mid-sweep: outputs clear immediately, no sweep_done, in-flight data dropped.
- Out-of-range addresses cannot occur (ADDR_W=4, DEPTH=16). If DEPTH<2^ADDR_W, the sweep still stops at DEPTH-1.

Test Plan:
- Reset: hold rst=0 with all reqs high → all acks 0 during reset, regfile_w_enable=0, busy=0, no valid pulses. After rst=1, wr1 is acked first.
- Simultaneous writes: wr0 (addr 3, data 14'h2AB5) and wr1 (addr 5, state 2'b10) in the same cycle.
  - wr1_ack cycle N, then w_en=01, addr 5, data 14'h0002.
  - wr0_ack cycle N+1, then w_en=11, addr 3, data 14'h2AB5.
- Single read: preload addr 7=14'h1FFD, rd_req addr 7 → rd_ack cycle N, rd_valid=1 with rd_data=14'h1FFD in cycle N+2, exactly 1 cycle wide.
- Full sweep of entries preloaded i*3: sweep_start → 16 sweep_valid pulses, indices 0..15 in order, data matching. sweep_done with index 15. First valid 2 cycles after start+1; total 18 cycles unpreempted.
- Sweep preemption: issue wr1 and rd_req during sweep index 6 → sweep stalls 2 cycles.
  - No duplicate or missing index.
  - Written value visible if that index is swept later.
  - sweep_done still arrives once.
- sweep_start repeated mid-sweep → ignored (single sweep_done). Async reset asserted at index 9 → valids stop, FSM IDLE, no sweep_done.

Source files
------------

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: single owner of the card regfile port set. Arbitrates
// the colour writer, the state writer, the single-card reader and the
// DEPTH-entry sweep engine onto one regfile operation per cycle.
// Grant priority: wr1 > wr0 > rd > sweep step.
module regfile_arbiter #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr0_req,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  output logic              wr0_ack,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [1:0]        wr1_state,
  output logic              wr1_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              sweep_start,
  output logic              sweep_valid,
  output logic [ADDR_W-1:0] sweep_index,
  output logic [DATA_W-1:0] sweep_data,
  output logic              sweep_done,
  output logic              busy,
  output logic [1:0]        regfile_w_enable,
  output logic [ADDR_W-1:0] regfile_w_address,
  output logic [DATA_W-1:0] regfile_w_data,
  output logic [ADDR_W-1:0] regfile_r_address,
  input  logic [DATA_W-1:0] regfile_r_data
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;

  logic                g_wr1, g_wr0, g_rd, g_sw;

  logic [1:0]          w_en_q;
  logic [ADDR_W-1:0]   w_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [ADDR_W-1:0]   r_addr_q;

  // Read tag pipeline: stage 1 = address presented, stage 2 = data returned.
  logic                rd_tag1_q, sw_tag1_q, last1_q;
  logic                rd_tag2_q, sw_tag2_q, last2_q;
  logic [ADDR_W-1:0]   idx2_q;
  logic [DATA_W-1:0]   rd_hold_q, sw_hold_q;

  // Fixed-priority grant; nothing is granted while reset is asserted.
  always_comb begin
    g_wr1 = rst & wr1_req;
    g_wr0 = rst & wr0_req & ~wr1_req;
    g_rd  = rst & rd_req & ~wr1_req & ~wr0_req;
    g_sw  = rst & (state_q == SWEEP) & ~wr1_req & ~wr0_req & ~rd_req;
  end

  assign wr1_ack = g_wr1;
  assign wr0_ack = g_wr0;
  assign rd_ack  = g_rd;

  // Sweep FSM next state: a preempted cycle simply leaves the counter alone.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sweep_start) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        if (g_sw) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (sw_tag2_q && last2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and sweep counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write port: enables are a one-cycle pulse, address/data hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_en_q   <= 2'b00;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      w_en_q <= 2'b00;
      if (g_wr1) begin
        w_en_q   <= 2'b01;
        w_addr_q <= wr1_addr;
        w_data_q <= {{(DATA_W-2){1'b0}}, wr1_state};
      end else if (g_wr0) begin
        w_en_q   <= 2'b11;
        w_addr_q <= wr0_addr;
        w_data_q <= wr0_data;
      end
    end
  end

  // Read issue: load the regfile address and launch a tag for the data slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_q  <= '0;
      rd_tag1_q <= 1'b0;
      sw_tag1_q <= 1'b0;
      last1_q   <= 1'b0;
    end else begin
      rd_tag1_q <= g_rd;
      sw_tag1_q <= g_sw;
      last1_q   <= g_sw && (cnt_q == LAST_IDX);
      if (g_rd)      r_addr_q <= rd_addr;
      else if (g_sw) r_addr_q <= cnt_q;
    end
  end

  // Data-return stage: tags arrive with the regfile data, results are held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_tag2_q <= 1'b0;
      sw_tag2_q <= 1'b0;
      last2_q   <= 1'b0;
      idx2_q    <= '0;
      rd_hold_q <= '0;
      sw_hold_q <= '0;
    end else begin
      rd_tag2_q <= rd_tag1_q;
      sw_tag2_q <= sw_tag1_q;
      last2_q   <= last1_q;
      if (sw_tag1_q) idx2_q    <= r_addr_q;
      if (rd_tag2_q) rd_hold_q <= regfile_r_data;
      if (sw_tag2_q) sw_hold_q <= regfile_r_data;
    end
  end

  assign regfile_w_enable  = w_en_q;
  assign regfile_w_address = w_addr_q;
  assign regfile_w_data    = w_data_q;
  assign regfile_r_address = r_addr_q;

  assign rd_valid    = rd_tag2_q;
  assign rd_data     = rd_tag2_q ? regfile_r_data : rd_hold_q;
  assign sweep_valid = sw_tag2_q;
  assign sweep_index = idx2_q;
  assign sweep_data  = sw_tag2_q ? regfile_r_data : sw_hold_q;
  assign sweep_done  = sw_tag2_q & last2_q;
  assign busy        = (state_q != IDLE) | rd_tag1_q | sw_tag1_q | rd_tag2_q | sw_tag2_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Testbench for regfile_arbiter: a registered-read regfile model sits on the
// DUT's regfile port; exp_mem holds the contents every write should produce.
module tb_regfile_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr0_req, wr1_req, rd_req, sweep_start;
  logic [3:0]  wr0_addr, wr1_addr, rd_addr;
  logic [13:0] wr0_data;
  logic [1:0]  wr1_state;
  logic        wr0_ack, wr1_ack, rd_ack, rd_valid;
  logic [13:0] rd_data, sweep_data;
  logic        sweep_valid, sweep_done, busy;
  logic [3:0]  sweep_index;
  logic [1:0]  regfile_w_enable;
  logic [3:0]  regfile_w_address, regfile_r_address;
  logic [13:0] regfile_w_data, regfile_r_data;

  int errors = 0;
  int checks = 0;

  logic [13:0] exp_mem [16];

  // Sweep scenario observations
  int          got_idx[$];
  logic [13:0] got_dat[$];
  int          got_cyc[$];
  int          done_cnt, done_cyc, done_idx;
  int          wr1_ack_cyc, rd_ack_cyc, rdv_cnt, rdv_cyc;
  logic [13:0] rdv_dat;
  logic        rst_valid, rst_busy, rst_done;
  logic [3:0]  rst_raddr;
  logic [1:0]  rst_wen;

  always #5 clk = ~clk;

  regfile_arbiter dut (
    .clk(clk), .rst(rst),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ack(wr0_ack),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_state(wr1_state), .wr1_ack(wr1_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .sweep_start(sweep_start), .sweep_valid(sweep_valid), .sweep_index(sweep_index),
    .sweep_data(sweep_data), .sweep_done(sweep_done), .busy(busy),
    .regfile_w_enable(regfile_w_enable), .regfile_w_address(regfile_w_address),
    .regfile_w_data(regfile_w_data), .regfile_r_address(regfile_r_address),
    .regfile_r_data(regfile_r_data)
  );

  // Regfile model: per-field write enables, one-cycle registered read.
  logic [13:0] mem [16];
  always @(posedge clk) begin
    if (regfile_w_enable[1]) mem[regfile_w_address][13:2] <= regfile_w_data[13:2];
    if (regfile_w_enable[0]) mem[regfile_w_address][1:0]  <= regfile_w_data[1:0];
    regfile_r_data <= mem[regfile_r_address];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic do_wr0(input logic [3:0] a, input logic [13:0] d);
    bit got = 0;
    wr0_req = 1'b1; wr0_addr = a; wr0_data = d;
    for (int n = 0; n < 8 && !got; n++) begin
      samp();
      if (wr0_ack === 1'b1) got = 1;
      tick();
    end
    wr0_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wr0_ack_timeout addr=%0d got no ack, need ack within 8 cycles", a);
    end else begin
      samp();
      if (regfile_w_enable !== 2'b11 || regfile_w_address !== a || regfile_w_data !== d) begin
        errors++;
        $display("FAIL wr0_write got en=%b addr=%0d data=%h need en=11 addr=%0d data=%h",
                 regfile_w_enable, regfile_w_address, regfile_w_data, a, d);
      end
      tick();
    end
    exp_mem[a] = d;
  endtask

  task automatic do_wr1(input logic [3:0] a, input logic [1:0] s);
    bit got = 0;
    wr1_req = 1'b1; wr1_addr = a; wr1_state = s;
    for (int n = 0; n < 8 && !got; n++) begin
      samp();
      if (wr1_ack === 1'b1) got = 1;
      tick();
    end
    wr1_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wr1_ack_timeout addr=%0d got no ack, need ack within 8 cycles", a);
    end else begin
      samp();
      if (regfile_w_enable !== 2'b01 || regfile_w_address !== a ||
          regfile_w_data !== {12'h000, s}) begin
        errors++;
        $display("FAIL wr1_write got en=%b addr=%0d data=%h need en=01 addr=%0d data=%h",
                 regfile_w_enable, regfile_w_address, regfile_w_data, a, {12'h000, s});
      end
      tick();
    end
    exp_mem[a][1:0] = s;
  endtask

  task automatic do_read(input logic [3:0] a);
    bit got = 0;
    rd_req = 1'b1; rd_addr = a;
    for (int n = 0; n < 8 && !got; n++) begin
      samp();
      if (rd_ack === 1'b1) got = 1;
      tick();
    end
    rd_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rd_ack_timeout addr=%0d got no ack, need ack within 8 cycles", a);
      return;
    end
    samp();
    checks++;
    if (rd_valid !== 1'b0 || regfile_r_address !== a || busy !== 1'b1) begin
      errors++;
      $display("FAIL rd_issue got valid=%b raddr=%0d busy=%b need valid=0 raddr=%0d busy=1",
               rd_valid, regfile_r_address, busy, a);
    end
    tick();
    samp();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_mem[a]) begin
      errors++;
      $display("FAIL rd_data addr=%0d got valid=%b data=%h need valid=1 data=%h",
               a, rd_valid, rd_data, exp_mem[a]);
    end
    tick();
    samp();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== exp_mem[a] || busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_after got valid=%b data=%h busy=%b need valid=0 data=%h busy=0",
               rd_valid, rd_data, busy, exp_mem[a]);
    end
    tick();
    $display("read addr=%0d data=%h", a, exp_mem[a]);
  endtask

  // Runs one sweep scenario and records what the DUT produced.
  // mode 0: plain, 1: wr1+rd preempt at index 6, 2: repeated start, 3: reset at index 9
  task automatic run_sweep(input int mode, input logic [1:0] pst);
    int rst_hold = 0;
    got_idx.delete(); got_dat.delete(); got_cyc.delete();
    done_cnt = 0; done_cyc = -1; done_idx = -1;
    wr1_ack_cyc = -1; rd_ack_cyc = -1; rdv_cnt = 0; rdv_cyc = -1; rdv_dat = '0;
    for (int c = 0; c < 40; c++) begin
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b1;
      end
      sweep_start = (c == 0) || (mode == 2 && (c == 5 || c == 17));
      if (mode == 1) begin
        wr1_req = (c == 7); wr1_addr = 4'd10; wr1_state = pst;
        rd_req = (c == 7 || c == 8); rd_addr = 4'd2;
        if (c == 7) exp_mem[10][1:0] = pst;
      end
      samp();
      if (sweep_valid === 1'b1) begin
        got_idx.push_back(int'(sweep_index));
        got_dat.push_back(sweep_data);
        got_cyc.push_back(c);
      end
      if (sweep_done === 1'b1) begin
        done_cnt++; done_cyc = c; done_idx = int'(sweep_index);
      end
      if (wr1_ack === 1'b1) wr1_ack_cyc = c;
      if (rd_ack === 1'b1) rd_ack_cyc = c;
      if (rd_valid === 1'b1) begin
        rdv_cnt++; rdv_cyc = c; rdv_dat = rd_data;
      end
      if (mode == 3 && rst && sweep_valid === 1'b1 && sweep_index == 4'd9) begin
        rst = 1'b0;
        #1;
        rst_valid = sweep_valid; rst_busy = busy; rst_done = sweep_done;
        rst_raddr = regfile_r_address; rst_wen = regfile_w_enable;
        rst_hold = 2;
      end
      tick();
    end
    sweep_start = 1'b0; wr1_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wr0_req = 1'b1; wr1_req = 1'b1; rd_req = 1'b1; sweep_start = 1'b1;
    wr0_addr = 4'd0; wr0_data = 14'h0; wr1_addr = 4'd0; wr1_state = 2'b00; rd_addr = 4'd0;
    for (int n = 0; n < 3; n++) begin
      samp();
      checks++;
      if ({wr0_ack, wr1_ack, rd_ack} !== 3'b000 || regfile_w_enable !== 2'b00 || busy !== 1'b0 ||
          rd_valid !== 1'b0 || sweep_valid !== 1'b0 || sweep_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold got acks=%b wen=%b busy=%b rv=%b sv=%b sd=%b need all 0",
                 {wr0_ack, wr1_ack, rd_ack}, regfile_w_enable, busy, rd_valid, sweep_valid, sweep_done);
      end
      tick();
    end
    rst = 1'b1; sweep_start = 1'b0;
    samp();
    checks++;
    if ({wr0_ack, wr1_ack, rd_ack} !== 3'b010 || regfile_r_address !== 4'd0 ||
        regfile_w_address !== 4'd0) begin
      errors++;
      $display("FAIL reset_first_grant got acks(wr0,wr1,rd)=%b raddr=%0d waddr=%0d need 010 0 0",
               {wr0_ack, wr1_ack, rd_ack}, regfile_r_address, regfile_w_address);
    end
    tick();
    wr0_req = 1'b0; wr1_req = 1'b0; rd_req = 1'b0;
    samp();
    checks++;
    if (regfile_w_enable !== 2'b01 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_wr1_write got wen=%b busy=%b need wen=01 busy=0", regfile_w_enable, busy);
    end
    tick();
    exp_mem[0][1:0] = 2'b00;
    $display("reset test done");
  endtask

  task automatic test_preload_random();
    for (int i = 0; i < 16; i++) do_wr0(4'(i), 14'($urandom));
    $display("preloaded 16 random words");
  endtask

  task automatic test_simul_writes();
    wr0_req = 1'b1; wr0_addr = 4'd3; wr0_data = 14'h2AB5;
    wr1_req = 1'b1; wr1_addr = 4'd5; wr1_state = 2'b10;
    samp();
    checks++;
    if (wr1_ack !== 1'b1 || wr0_ack !== 1'b0) begin
      errors++;
      $display("FAIL simul_cycleN got wr1_ack=%b wr0_ack=%b need 1 0", wr1_ack, wr0_ack);
    end
    tick();
    wr1_req = 1'b0;
    samp();
    checks++;
    if (wr0_ack !== 1'b1 || regfile_w_enable !== 2'b01 || regfile_w_address !== 4'd5 ||
        regfile_w_data !== 14'h0002) begin
      errors++;
      $display("FAIL simul_cycleN1 got wr0_ack=%b en=%b addr=%0d data=%h need 1 01 5 0002",
               wr0_ack, regfile_w_enable, regfile_w_address, regfile_w_data);
    end
    tick();
    wr0_req = 1'b0;
    samp();
    checks++;
    if (regfile_w_enable !== 2'b11 || regfile_w_address !== 4'd3 || regfile_w_data !== 14'h2AB5) begin
      errors++;
      $display("FAIL simul_cycleN2 got en=%b addr=%0d data=%h need 11 3 2AB5",
               regfile_w_enable, regfile_w_address, regfile_w_data);
    end
    tick();
    samp();
    checks++;
    if (regfile_w_enable !== 2'b00) begin
      errors++;
      $display("FAIL simul_idle_wen got en=%b need 00", regfile_w_enable);
    end
    tick();
    exp_mem[5][1:0] = 2'b10;
    exp_mem[3] = 14'h2AB5;
    do_read(4'd5);
    do_read(4'd3);
    $display("simultaneous write test done");
  endtask

  task automatic test_single_read();
    do_wr0(4'd7, 14'h1FFD);
    do_read(4'd7);
  endtask

  task automatic test_random_rw();
    for (int n = 0; n < 24; n++) begin
      int op = $urandom_range(0, 2);
      logic [3:0] a = 4'($urandom);
      if (op == 0)      do_wr0(a, 14'($urandom));
      else if (op == 1) do_wr1(a, 2'($urandom));
      else              do_read(a);
    end
    $display("random read/write test done");
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 16; i++) do_wr0(4'(i), 14'(i * 3));
    run_sweep(0, 2'b00);
    checks++;
    if (got_idx.size() != 16) begin
      errors++;
      $display("FAIL sweep_count got %0d valids need 16", got_idx.size());
    end
    for (int k = 0; k < got_idx.size() && k < 16; k++) begin
      checks++;
      if (got_idx[k] != k || got_dat[k] !== 14'(k * 3)) begin
        errors++;
        $display("FAIL sweep_entry k=%0d got idx=%0d data=%h need idx=%0d data=%h",
                 k, got_idx[k], got_dat[k], k, 14'(k * 3));
      end
    end
    checks++;
    if (got_idx.size() == 0 || got_cyc[0] != 3) begin
      errors++;
      $display("FAIL sweep_first_latency got cycle=%0d need 3",
               (got_cyc.size() > 0) ? got_cyc[0] : -1);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 18 || done_idx != 15) begin
      errors++;
      $display("FAIL sweep_done got cnt=%0d cyc=%0d idx=%0d need 1 18 15", done_cnt, done_cyc, done_idx);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_busy_after got busy=%b need 0", busy);
    end
    $display("full sweep: %0d valids, done at cycle %0d", got_idx.size(), done_cyc);
  endtask

  task automatic test_preempt();
    logic [1:0] pst = 2'($urandom);
    run_sweep(1, pst);
    checks++;
    if (got_idx.size() != 16) begin
      errors++;
      $display("FAIL preempt_count got %0d valids need 16", got_idx.size());
    end
    for (int k = 0; k < got_idx.size() && k < 16; k++) begin
      checks++;
      if (got_idx[k] != k || got_dat[k] !== exp_mem[k]) begin
        errors++;
        $display("FAIL preempt_entry k=%0d got idx=%0d data=%h need idx=%0d data=%h",
                 k, got_idx[k], got_dat[k], k, exp_mem[k]);
      end
    end
    checks++;
    if (wr1_ack_cyc != 7 || rd_ack_cyc != 8) begin
      errors++;
      $display("FAIL preempt_acks got wr1@%0d rd@%0d need wr1@7 rd@8", wr1_ack_cyc, rd_ack_cyc);
    end
    checks++;
    if (rdv_cnt != 1 || rdv_cyc != 10 || rdv_dat !== exp_mem[2]) begin
      errors++;
      $display("FAIL preempt_read got cnt=%0d cyc=%0d data=%h need 1 10 %h",
               rdv_cnt, rdv_cyc, rdv_dat, exp_mem[2]);
    end
    checks++;
    if (got_cyc.size() < 7 || got_cyc[5] != 8 || got_cyc[6] != 11) begin
      errors++;
      $display("FAIL preempt_stall got idx5@%0d idx6@%0d need 8 and 11",
               (got_cyc.size() > 5) ? got_cyc[5] : -1, (got_cyc.size() > 6) ? got_cyc[6] : -1);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 20 || done_idx != 15) begin
      errors++;
      $display("FAIL preempt_done got cnt=%0d cyc=%0d idx=%0d need 1 20 15", done_cnt, done_cyc, done_idx);
    end
    $display("preempted sweep: %0d valids, done at cycle %0d", got_idx.size(), done_cyc);
  endtask

  task automatic test_restart_ignored();
    run_sweep(2, 2'b00);
    checks++;
    if (got_idx.size() != 16 || done_cnt != 1 || done_cyc != 18) begin
      errors++;
      $display("FAIL restart_ignored got valids=%0d done_cnt=%0d done_cyc=%0d need 16 1 18",
               got_idx.size(), done_cnt, done_cyc);
    end
    for (int k = 0; k < got_idx.size() && k < 16; k++) begin
      checks++;
      if (got_idx[k] != k || got_dat[k] !== exp_mem[k]) begin
        errors++;
        $display("FAIL restart_entry k=%0d got idx=%0d data=%h need idx=%0d data=%h",
                 k, got_idx[k], got_dat[k], k, exp_mem[k]);
      end
    end
    $display("restart-ignored sweep: %0d valids", got_idx.size());
  endtask

  task automatic test_reset_mid_sweep();
    run_sweep(3, 2'b00);
    checks++;
    if (rst_valid !== 1'b0 || rst_busy !== 1'b0 || rst_done !== 1'b0 ||
        rst_raddr !== 4'd0 || rst_wen !== 2'b00) begin
      errors++;
      $display("FAIL midreset_immediate got sv=%b busy=%b sd=%b raddr=%0d wen=%b need 0 0 0 0 00",
               rst_valid, rst_busy, rst_done, rst_raddr, rst_wen);
    end
    checks++;
    if (got_idx.size() != 10 || done_cnt != 0) begin
      errors++;
      $display("FAIL midreset_stop got valids=%0d done_cnt=%0d need 10 0", got_idx.size(), done_cnt);
    end
    checks++;
    if (busy !== 1'b0 || rst !== 1'b1) begin
      errors++;
      $display("FAIL midreset_idle got busy=%b rst=%b need 0 1", busy, rst);
    end
    do_read(4'd9);
    $display("reset-mid-sweep: %0d valids before reset", got_idx.size());
  endtask

  initial begin
    rst = 1'b0;
    wr0_req = 1'b0; wr1_req = 1'b0; rd_req = 1'b0; sweep_start = 1'b0;
    wr0_addr = '0; wr0_data = '0; wr1_addr = '0; wr1_state = '0; rd_addr = '0;
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    test_reset();
    test_preload_random();
    test_simul_writes();
    test_single_read();
    test_random_rw();
    test_sweep();
    test_preempt();
    test_restart_ignored();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
